// File: rtl/rv32i_instr_encoder_if.sv
// ---------------------------------------------------------------------------
// rv32i_instr_encoder_if
//   Bundles the request handshake, the instruction-memory write port and the
//   status outputs of rv32i_instr_encoder.
//   master : harness / boot-loader side (issues operations, acks writes).
//   slave  : the encoder itself.
//   Signals:
//     start            restart the program load at BASE_ADDR
//     op_valid/ready   request handshake
//     op_code,rd,rs1,rs2,imm   symbolic operation fields
//     imem_we/ack/addr/wdata   instruction-memory write port
//     count, full, err, err_pulse   load status
// ---------------------------------------------------------------------------
interface rv32i_instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              op_valid;
    logic              op_ready;
    logic [5:0]        op_code;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [12:0]       imm;
    logic              imem_we;
    logic              imem_ack;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic              err_pulse;

    // The master side also plays the memory, so it drives imem_ack.
    modport master (
        output start, op_valid, op_code, rd, rs1, rs2, imm, imem_ack,
        input  op_ready, imem_we, imem_addr, imem_wdata, count, full, err, err_pulse
    );

    modport slave (
        input  start, op_valid, op_code, rd, rs1, rs2, imm, imem_ack,
        output op_ready, imem_we, imem_addr, imem_wdata, count, full, err, err_pulse
    );
endinterface

// File: rtl/rv32i_instr_encoder.sv
// ---------------------------------------------------------------------------
// rv32i_instr_encoder
//   Packs one symbolic RV32I operation (R / I-ALU / shift-imm / load / store /
//   branch subset) per handshake into a 32-bit instruction word and writes it
//   into instruction memory at an auto-incrementing word address.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   rv32i_instr_encoder_if.slave (handshake, memory port, status)
//   Flow: IDLE -accept-> ENC -legal-> WR -ack-> IDLE (or FULL at last addr)
//                             ENC -illegal-> IDLE with err_pulse/err.
// ---------------------------------------------------------------------------
module rv32i_instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    rv32i_instr_encoder_if.slave bus
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST     = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_S  = 7'b0100011;
    localparam logic [6:0] OPC_B  = 7'b1100011;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR, S_FULL} state_t;
    typedef enum logic [2:0] {C_R, C_I, C_SH, C_LD, C_S, C_B, C_BAD} cls_t;

    state_t            state_q, state_d;
    logic [5:0]        op_code_q, op_code_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic [12:0]       imm_q, imm_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic              err_pulse_q, err_pulse_d;

    cls_t        cls;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic        op_ready;

    // ------------------------------------------------------------------
    // Mnemonic table: instruction class, funct3, funct7
    // ------------------------------------------------------------------
    always_comb begin
        cls = C_BAD;
        f3  = 3'b000;
        f7  = 7'b0000000;
        case (op_code_q)
            6'd0:  begin cls = C_R;  f3 = 3'b000; end
            6'd1:  begin cls = C_R;  f3 = 3'b000; f7 = F7_ALT; end
            6'd2:  begin cls = C_R;  f3 = 3'b111; end
            6'd3:  begin cls = C_R;  f3 = 3'b110; end
            6'd4:  begin cls = C_R;  f3 = 3'b100; end
            6'd5:  begin cls = C_R;  f3 = 3'b010; end
            6'd6:  begin cls = C_R;  f3 = 3'b011; end
            6'd7:  begin cls = C_R;  f3 = 3'b001; end
            6'd8:  begin cls = C_R;  f3 = 3'b101; end
            6'd9:  begin cls = C_R;  f3 = 3'b101; f7 = F7_ALT; end
            6'd10: begin cls = C_I;  f3 = 3'b000; end
            6'd11: begin cls = C_I;  f3 = 3'b111; end
            6'd12: begin cls = C_I;  f3 = 3'b110; end
            6'd13: begin cls = C_I;  f3 = 3'b100; end
            6'd14: begin cls = C_I;  f3 = 3'b010; end
            6'd15: begin cls = C_I;  f3 = 3'b011; end
            6'd16: begin cls = C_SH; f3 = 3'b001; end
            6'd17: begin cls = C_SH; f3 = 3'b101; end
            6'd18: begin cls = C_SH; f3 = 3'b101; f7 = F7_ALT; end
            6'd19: begin cls = C_LD; f3 = 3'b000; end
            6'd20: begin cls = C_LD; f3 = 3'b001; end
            6'd21: begin cls = C_LD; f3 = 3'b010; end
            6'd22: begin cls = C_LD; f3 = 3'b100; end
            6'd23: begin cls = C_LD; f3 = 3'b101; end
            6'd24: begin cls = C_S;  f3 = 3'b000; end
            6'd25: begin cls = C_S;  f3 = 3'b001; end
            6'd26: begin cls = C_S;  f3 = 3'b010; end
            6'd27: begin cls = C_B;  f3 = 3'b000; end
            6'd28: begin cls = C_B;  f3 = 3'b001; end
            6'd29: begin cls = C_B;  f3 = 3'b100; end
            6'd30: begin cls = C_B;  f3 = 3'b101; end
            6'd31: begin cls = C_B;  f3 = 3'b110; end
            6'd32: begin cls = C_B;  f3 = 3'b111; end
            default: cls = C_BAD;
        endcase
    end

    // ------------------------------------------------------------------
    // Field packing and immediate range checks on the latched request
    // ------------------------------------------------------------------
    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b0;
        case (cls)
            C_R: begin
                enc_word  = {f7, rs2_q, rs1_q, f3, rd_q, OPC_R};
                enc_legal = 1'b1;
            end
            C_I: begin
                enc_word  = {imm_q[11:0], rs1_q, f3, rd_q, OPC_I};
                // 12-bit signed range: bit 12 must be a copy of the sign bit
                enc_legal = (imm_q[12] == imm_q[11]);
            end
            C_SH: begin
                enc_word  = {f7, imm_q[4:0], rs1_q, f3, rd_q, OPC_I};
                enc_legal = (imm_q[12:5] == 8'h00);
            end
            C_LD: begin
                enc_word  = {imm_q[11:0], rs1_q, f3, rd_q, OPC_LD};
                enc_legal = (imm_q[12] == imm_q[11]);
            end
            C_S: begin
                enc_word  = {imm_q[11:5], rs2_q, rs1_q, f3, imm_q[4:0], OPC_S};
                enc_legal = (imm_q[12] == imm_q[11]);
            end
            C_B: begin
                enc_word  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3,
                             imm_q[4:1], imm_q[11], OPC_B};
                // branch targets are halfword aligned
                enc_legal = (imm_q[0] == 1'b0);
            end
            default: begin
                enc_word  = 32'h0;
                enc_legal = 1'b0;
            end
        endcase
    end

    assign op_ready = (state_q == S_IDLE) && !full_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        op_code_d   = op_code_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        imm_d       = imm_q;
        wdata_d     = wdata_q;
        addr_d      = addr_q;
        count_d     = count_q;
        full_d      = full_q;
        err_d       = err_q;
        err_pulse_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.op_valid && op_ready) begin
                    op_code_d = bus.op_code;
                    rd_d      = bus.rd;
                    rs1_d     = bus.rs1;
                    rs2_d     = bus.rs2;
                    imm_d     = bus.imm;
                    state_d   = S_ENC;
                end
            end
            S_ENC: begin
                if (enc_legal) begin
                    wdata_d = enc_word;
                    state_d = S_WR;
                end else begin
                    err_pulse_d = 1'b1;
                    err_d       = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_WR: begin
                if (bus.imem_ack) begin
                    count_d = count_q + CNT_ONE;
                    // Stop at the top of memory instead of wrapping.
                    if (addr_q == LAST) begin
                        full_d  = 1'b1;
                        state_d = S_FULL;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_FULL: begin
                state_d = S_FULL;
            end
            default: state_d = S_IDLE;
        endcase

        // Restart overrides everything except reset; aborts any pending write.
        if (bus.start) begin
            state_d     = S_IDLE;
            addr_d      = BASE;
            count_d     = '0;
            full_d      = 1'b0;
            err_d       = 1'b0;
            err_pulse_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_code_q   <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            wdata_q     <= '0;
            addr_q      <= BASE;
            count_q     <= '0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_code_q   <= op_code_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            imm_q       <= imm_d;
            wdata_q     <= wdata_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            err_q       <= err_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign bus.op_ready   = op_ready;
    assign bus.imem_we    = (state_q == S_WR);
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.count      = count_q;
    assign bus.full       = full_q;
    assign bus.err        = err_q;
    assign bus.err_pulse  = err_pulse_q;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_rv32i_instr_encoder
//   Directed test of rv32i_instr_encoder with a 4-word memory (ADDR_W=2) so
//   the full / restart behaviour is reachable in a few operations.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_rv32i_instr_encoder;

    localparam int ADDR_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rv32i_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    rv32i_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int pulses   = 0;

    always @(posedge clk) begin
        if (bus.imem_we && bus.imem_ack) wr_cnt++;
        if (bus.err_pulse) pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request at a falling edge; returns at the falling edge of
    // the cycle after acceptance (encoder in ENC).
    task automatic issue(input string tag, input logic [5:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
        int n = 0;
        while (bus.op_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " op_ready before accept"}, 32'(bus.op_ready), 32'd1);
        bus.op_code  = op;
        bus.rd       = rd;
        bus.rs1      = rs1;
        bus.rs2      = rs2;
        bus.imm      = imm;
        bus.op_valid = 1'b1;
        @(negedge clk);
        bus.op_valid = 1'b0;
        $display("issue %s op=%0d rd=%0d rs1=%0d rs2=%0d imm=0x%0h", tag, op, rd, rs1, rs2, imm);
    endtask

    // Wait for the write, hold ack low for 'delay' cycles, then ack.
    task automatic expect_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                                input int delay, input logic ready_after);
        int n = 0;
        while (bus.imem_we !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, " write latency"}, 32'(n), 32'd1);
        check({tag, " addr"}, 32'(bus.imem_addr), addr);
        check({tag, " wdata"}, bus.imem_wdata, data);
        check({tag, " op_ready in WR"}, 32'(bus.op_ready), 32'd0);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check({tag, " we held"}, 32'(bus.imem_we), 32'd1);
            check({tag, " addr held"}, 32'(bus.imem_addr), addr);
            check({tag, " wdata held"}, bus.imem_wdata, data);
            check({tag, " op_ready held low"}, 32'(bus.op_ready), 32'd0);
        end
        bus.imem_ack = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check({tag, " we dropped"}, 32'(bus.imem_we), 32'd0);
        check({tag, " op_ready after"}, 32'(bus.op_ready), 32'(ready_after));
        $display("write %s addr=%0d data=0x%08h", tag, bus.imem_addr, bus.imem_wdata);
    endtask

    task automatic issue_bad(input string tag, input logic [5:0] op, input logic [12:0] imm);
        issue(tag, op, 5'd1, 5'd2, 5'd3, imm);
        check({tag, " no pulse in ENC"}, 32'(bus.err_pulse), 32'd0);
        @(negedge clk);
        check({tag, " err_pulse"}, 32'(bus.err_pulse), 32'd1);
        check({tag, " err"}, 32'(bus.err), 32'd1);
        check({tag, " op_ready"}, 32'(bus.op_ready), 32'd1);
        check({tag, " no we"}, 32'(bus.imem_we), 32'd0);
        $display("reject %s op=%0d imm=0x%0h", tag, op, imm);
    endtask

    task automatic pulse_start(input string tag);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " addr"}, 32'(bus.imem_addr), 32'd0);
        check({tag, " count"}, 32'(bus.count), 32'd0);
        check({tag, " full"}, 32'(bus.full), 32'd0);
        check({tag, " err"}, 32'(bus.err), 32'd0);
        check({tag, " op_ready"}, 32'(bus.op_ready), 32'd1);
        $display("start %s", tag);
    endtask

    initial begin
        int w0;
        bus.start    = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_code  = '0;
        bus.rd       = '0;
        bus.rs1      = '0;
        bus.rs2      = '0;
        bus.imm      = '0;
        bus.imem_ack = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst op_ready", 32'(bus.op_ready), 32'd1);
        check("rst we", 32'(bus.imem_we), 32'd0);
        check("rst addr", 32'(bus.imem_addr), 32'd0);
        check("rst wdata", bus.imem_wdata, 32'd0);
        check("rst count", 32'(bus.count), 32'd0);
        check("rst full", 32'(bus.full), 32'd0);
        check("rst err", 32'(bus.err), 32'd0);
        check("rst err_pulse", 32'(bus.err_pulse), 32'd0);

        // add x3,x1,x2 with immediate ack
        issue("add", 6'd0, 5'd3, 5'd1, 5'd2, 13'd0);
        expect_write("add", 32'd0, 32'h002081B3, 0, 1'b1);
        check("add count", 32'(bus.count), 32'd1);
        check("add wr_cnt", 32'(wr_cnt), 32'd1);
        pulse_start("start1");

        // addi / sw / bne program
        issue("addi", 6'd10, 5'd5, 5'd0, 5'd0, 13'h1FFF);
        expect_write("addi", 32'd0, 32'hFFF00293, 0, 1'b1);
        issue("sw", 6'd26, 5'd0, 5'd1, 5'd2, 13'd8);
        expect_write("sw", 32'd1, 32'h0020A423, 0, 1'b1);
        issue("bne", 6'd28, 5'd0, 5'd1, 5'd2, 13'd8);
        expect_write("bne", 32'd2, 32'h00209463, 0, 1'b1);
        check("prog count", 32'(bus.count), 32'd3);
        pulse_start("start2");

        // Slow ack, then fill the memory
        w0 = wr_cnt;
        issue("sub", 6'd1, 5'd1, 5'd2, 5'd3, 13'd0);
        expect_write("sub", 32'd0, 32'h403100B3, 3, 1'b1);
        check("slow single write", 32'(wr_cnt - w0), 32'd1);
        issue("srai", 6'd18, 5'd4, 5'd5, 5'd0, 13'd7);
        expect_write("srai", 32'd1, 32'h4072D213, 0, 1'b1);
        issue("lw", 6'd21, 5'd6, 5'd7, 5'd0, 13'h1FFC);
        expect_write("lw", 32'd2, 32'hFFC3A303, 0, 1'b1);
        issue("beq", 6'd27, 5'd0, 5'd1, 5'd2, 13'h1FFC);
        expect_write("beq", 32'd3, 32'hFE208EE3, 0, 1'b0);
        check("full flag", 32'(bus.full), 32'd1);
        check("full count", 32'(bus.count), 32'd4);
        check("full addr no wrap", 32'(bus.imem_addr), 32'd3);
        w0 = wr_cnt;
        bus.op_code  = 6'd0;
        bus.op_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full ignores op_ready", 32'(bus.op_ready), 32'd0);
            check("full ignores we", 32'(bus.imem_we), 32'd0);
        end
        bus.op_valid = 1'b0;
        check("full no writes", 32'(wr_cnt - w0), 32'd0);
        pulse_start("start3");

        // Illegal requests
        w0 = wr_cnt;
        pulses = 0;
        issue_bad("addi 2048", 6'd10, 13'h0800);
        issue_bad("slli 32", 6'd16, 13'd32);
        issue_bad("beq odd", 6'd27, 13'd3);
        issue_bad("op 40", 6'd40, 13'd0);
        @(negedge clk);
        check("bad pulse count", 32'(pulses), 32'd4);
        check("bad pulse cleared", 32'(bus.err_pulse), 32'd0);
        check("bad err sticky", 32'(bus.err), 32'd1);
        check("bad no writes", 32'(wr_cnt - w0), 32'd0);
        check("bad addr unchanged", 32'(bus.imem_addr), 32'd0);
        check("bad count unchanged", 32'(bus.count), 32'd0);
        pulse_start("start4");

        // Reset in the middle of a pending write
        issue("add2", 6'd0, 5'd3, 5'd1, 5'd2, 13'd0);
        expect_write("add2", 32'd0, 32'h002081B3, 0, 1'b1);
        issue("or", 6'd3, 5'd1, 5'd1, 5'd1, 13'd0);
        @(negedge clk);
        check("pre-rst we", 32'(bus.imem_we), 32'd1);
        check("pre-rst addr", 32'(bus.imem_addr), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid-rst we", 32'(bus.imem_we), 32'd0);
        check("mid-rst addr", 32'(bus.imem_addr), 32'd0);
        check("mid-rst count", 32'(bus.count), 32'd0);
        check("mid-rst op_ready", 32'(bus.op_ready), 32'd1);
        check("mid-rst wdata", bus.imem_wdata, 32'd0);
        $display("reset during write done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
